// File: rtl/rom_pkg.sv
// Shared types, parameter bounds and load-address helper for loadable_rom.
package rom_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    LOCKED  = 2'd2
  } rom_state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;
  localparam int ADDR_W_MAX  = 12;

  // Increment modulo 2**depth; callers truncate the result to their own width.
  function automatic logic [ADDR_W_MAX-1:0] next_load_addr(
    input logic [ADDR_W_MAX-1:0] addr,
    input int unsigned           depth
  );
    logic [ADDR_W_MAX:0] mask;
    mask = ((ADDR_W_MAX+1)'(1) << depth) - (ADDR_W_MAX+1)'(1);
    return (addr + ADDR_W_MAX'(1)) & mask[ADDR_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/rom_rd_pipe.sv
// Read delay line: LATENCY-1 valid/address stages feeding a data output register.
// The output register only reloads on a valid beat, so dropped requests leave it untouched.
module rom_rd_pipe
  import rom_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 5,
  parameter int LATENCY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [DEPTH-1:0] i_addr,
  output logic [DEPTH-1:0] o_rd_addr,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             w_tail_valid;
  logic [DEPTH-1:0] w_tail_addr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  generate
    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("rom_rd_pipe: LATENCY out of range");
    end

    if (LATENCY > 1) begin : g_stages
      logic [LATENCY-2:0] r_vld;
      logic [DEPTH-1:0]   r_addr [LATENCY-1];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_vld <= '0;
          for (int k = 0; k < LATENCY-1; k++) r_addr[k] <= '0;
        end else begin
          r_vld[0]  <= i_valid;
          r_addr[0] <= i_addr;
          for (int k = 1; k < LATENCY-1; k++) begin
            r_vld[k]  <= r_vld[k-1];
            r_addr[k] <= r_addr[k-1];
          end
        end
      end

      assign w_tail_valid = r_vld[LATENCY-2];
      assign w_tail_addr  = r_addr[LATENCY-2];
    end else begin : g_direct
      assign w_tail_valid = i_valid;
      assign w_tail_addr  = i_addr;
    end
  endgenerate

  assign o_rd_addr = w_tail_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_tail_valid;
      if (w_tail_valid) r_data <= i_rd_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/loadable_rom.sv
// Loadable ROM: one-shot valid/ready load with running XOR checksum, then locked
// pipelined reads behind a CS/OE tri-state bus.
module loadable_rom
  import rom_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 5,
  parameter int LATENCY = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_START,
  input  logic             LOAD_VALID,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic             LOAD_READY,
  output logic             LOAD_DONE,
  output logic [WIDTH-1:0] CHECKSUM,
  input  logic [DEPTH-1:0] ADDRESS_BUS,
  input  logic             CS,
  input  logic             OE,
  output logic [WIDTH-1:0] DATA_BUS,
  output logic             DATA_VALID
);

  generate
    if (WIDTH < 1 || WIDTH > 64 || DEPTH < 1 || DEPTH > ADDR_W_MAX ||
        LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_params
      $error("loadable_rom: illegal WIDTH/DEPTH/LATENCY");
    end
  endgenerate

  rom_state_t       r_state;
  rom_state_t       w_state_nxt;
  logic [DEPTH-1:0] r_load_addr;
  logic [WIDTH-1:0] r_checksum;
  logic             r_load_ready;
  logic             r_load_done;
  logic             w_accept;
  logic             w_restart;
  logic             w_rd_req;
  logic [DEPTH-1:0] w_rd_addr;
  logic [WIDTH-1:0] w_rd_data;
  logic [WIDTH-1:0] w_dout;

  logic [WIDTH-1:0] r_mem [2**DEPTH];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (LOAD_START) w_state_nxt = LOADING;
      end
      LOADING: begin
        // A restart outranks a word presented in the same cycle.
        if (LOAD_START) begin
          w_restart = 1'b1;
        end else if (LOAD_VALID) begin
          w_accept = 1'b1;
          if (&r_load_addr) w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        w_state_nxt = LOCKED;
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= EMPTY;
      r_load_addr  <= '0;
      r_checksum   <= '0;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_ready <= (w_state_nxt == LOADING);
      r_load_done  <= (w_state_nxt == LOCKED);
      if (r_state == EMPTY || w_restart) begin
        r_load_addr <= '0;
        r_checksum  <= '0;
      end else if (w_accept) begin
        r_load_addr <= DEPTH'(next_load_addr(ADDR_W_MAX'(r_load_addr), DEPTH));
        r_checksum  <= r_checksum ^ LOAD_DATA;
      end
    end
  end

  // Contents deliberately survive reset; only an accepted load word writes.
  always_ff @(posedge CLK) begin
    if (w_accept) r_mem[r_load_addr] <= LOAD_DATA;
  end

  assign w_rd_req  = (r_state == LOCKED) && !CS && OE;
  assign w_rd_data = r_mem[w_rd_addr];

  rom_rd_pipe #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) u_rd_pipe (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_valid  (w_rd_req),
    .i_addr   (ADDRESS_BUS),
    .o_rd_addr(w_rd_addr),
    .i_rd_data(w_rd_data),
    .o_valid  (DATA_VALID),
    .o_data   (w_dout)
  );

  assign LOAD_READY = r_load_ready;
  assign LOAD_DONE  = r_load_done;
  assign CHECKSUM   = r_checksum;
  assign DATA_BUS   = (!CS && OE) ? w_dout : {WIDTH{1'bz}};

endmodule

// File: tb/tb_loadable_rom.sv
// Self-checking bench for loadable_rom (WIDTH=8, DEPTH=5, LATENCY=2): directed load/read
// tables plus a randomized read phase scored against an array-based memory model.
module tb_loadable_rom;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 5;
  localparam int LATENCY = 2;
  localparam int NWORDS  = 1 << DEPTH;

  logic             CLK = 1'b0;
  logic             RST;
  logic             LOAD_START;
  logic             LOAD_VALID;
  logic [WIDTH-1:0] LOAD_DATA;
  logic             LOAD_READY;
  logic             LOAD_DONE;
  logic [WIDTH-1:0] CHECKSUM;
  logic [DEPTH-1:0] ADDRESS_BUS;
  logic             CS;
  logic             OE;
  wire  [WIDTH-1:0] DATA_BUS;
  logic             DATA_VALID;

  always #5 CLK = ~CLK;

  loadable_rom #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD_START (LOAD_START),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_DATA  (LOAD_DATA),
    .LOAD_READY (LOAD_READY),
    .LOAD_DONE  (LOAD_DONE),
    .CHECKSUM   (CHECKSUM),
    .ADDRESS_BUS(ADDRESS_BUS),
    .CS         (CS),
    .OE         (OE),
    .DATA_BUS   (DATA_BUS),
    .DATA_VALID (DATA_VALID)
  );

  typedef struct {
    logic             cs;
    logic             oe;
    logic [DEPTH-1:0] addr;
    logic             exp_valid;
    logic             exp_z;
    logic [WIDTH-1:0] exp_bus;
  } vec_t;

  vec_t             vecs[12];
  logic [WIDTH-1:0] model_mem [NWORDS];
  logic [WIDTH-1:0] model_cks;
  logic [WIDTH-1:0] exp_reg;
  bit               req_hist[$];
  logic [DEPTH-1:0] addr_hist[$];
  int               n_pass  = 0;
  int               n_total = 0;
  int               cnt;
  int               acc;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // A released bus reads as Z, or as 0 where nets resolve to two states.
  task automatic chk_z(input string name, input logic [WIDTH-1:0] act);
    n_total++;
    if ($isunknown(act) || act == '0) n_pass++;
    else $display("FAIL %s: actual=%h required=Z", name, act);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; LOAD_START = 1'b0; LOAD_VALID = 1'b0; LOAD_DATA = '0;
    ADDRESS_BUS = 5'd3; CS = 1'b0; OE = 1'b1;

    // Read table after loading 0x00..0x1F; data arrives one check later than its request.
    vecs[0]  = '{1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 8'h03};
    vecs[2]  = '{1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 8'h07};
    vecs[3]  = '{1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 8'h1F};
    vecs[4]  = '{1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 8'h05};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 5'd16, 1'b0, 1'b0, 8'h09};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 5'd16, 1'b0, 1'b0, 8'h10};
    vecs[11] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 8'h00};

    // Reset state, then requests while EMPTY must be dropped.
    step(); step();
    chk("rst_load_ready", LOAD_READY, 1'b0);
    chk("rst_load_done", LOAD_DONE, 1'b0);
    chk("rst_checksum", CHECKSUM, 8'h00);
    chk("rst_data_valid", DATA_VALID, 1'b0);
    chk("rst_data_bus", DATA_BUS, 8'h00);
    RST = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (DATA_VALID) cnt++;
    end
    chk("empty_read_pulses", cnt, 0);
    chk("empty_read_bus", DATA_BUS, 8'h00);
    chk("empty_load_done", LOAD_DONE, 1'b0);

    // Load 0x00..0x1F back to back.
    CS = 1'b1;
    LOAD_START = 1'b1;
    step();
    LOAD_START = 1'b0;
    cnt = 0;
    for (int i = 0; i < NWORDS; i++) begin
      LOAD_VALID = 1'b1;
      LOAD_DATA  = WIDTH'(i);
      if (LOAD_READY) cnt++;
      if (i == NWORDS-1) chk("done_before_last", LOAD_DONE, 1'b0);
      step();
    end
    LOAD_VALID = 1'b0;
    chk("ready_cycles", cnt, NWORDS);
    chk("load_done", LOAD_DONE, 1'b1);
    chk("load_ready_off", LOAD_READY, 1'b0);
    chk("checksum_seq", CHECKSUM, 8'h00);

    // LOCKED ignores load traffic.
    LOAD_START = 1'b1; LOAD_VALID = 1'b1; LOAD_DATA = 8'h55;
    step();
    LOAD_START = 1'b0; LOAD_VALID = 1'b0;
    step();
    chk("locked_checksum", CHECKSUM, 8'h00);
    chk("locked_done", LOAD_DONE, 1'b1);
    chk("locked_ready", LOAD_READY, 1'b0);

    for (int k = 0; k < 12; k++) begin
      CS = vecs[k].cs; OE = vecs[k].oe; ADDRESS_BUS = vecs[k].addr;
      step();
      chk($sformatf("tbl_valid[%0d]", k), DATA_VALID, vecs[k].exp_valid);
      if (vecs[k].exp_z) chk_z($sformatf("tbl_bus_z[%0d]", k), DATA_BUS);
      else chk($sformatf("tbl_bus[%0d]", k), DATA_BUS, vecs[k].exp_bus);
    end
    CS = 1'b1; OE = 1'b0;
    step(); step();

    // Restart mid-load: the word presented with LOAD_START is dropped.
    RST = 1'b1;
    step();
    RST = 1'b0;
    LOAD_START = 1'b1;
    step();
    LOAD_START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      LOAD_VALID = 1'b1; LOAD_DATA = WIDTH'($urandom);
      step();
    end
    LOAD_START = 1'b1; LOAD_VALID = 1'b1; LOAD_DATA = 8'hAA;
    step();
    LOAD_START = 1'b0;
    chk("restart_checksum", CHECKSUM, 8'h00);
    chk("restart_ready", LOAD_READY, 1'b1);

    acc = 0; model_cks = '0;
    for (int i = 0; i < 400 && acc < NWORDS; i++) begin
      LOAD_VALID = ($urandom % 4) != 0;
      LOAD_DATA  = WIDTH'($urandom);
      if (LOAD_VALID) begin
        model_mem[acc] = LOAD_DATA;
        model_cks      = model_cks ^ LOAD_DATA;
        acc++;
      end
      step();
    end
    LOAD_VALID = 1'b0;
    chk("reload_words", acc, NWORDS);
    chk("reload_done", LOAD_DONE, 1'b1);
    chk("reload_checksum", CHECKSUM, model_cks);

    // Random reads scored against the model; the first read hits address 0.
    exp_reg = '0;
    for (int i = 0; i < 200; i++) begin
      if (i == 0) begin
        CS = 1'b0; OE = 1'b1; ADDRESS_BUS = '0;
      end else begin
        CS = ($urandom % 4) == 0;
        OE = ($urandom % 5) != 0;
        ADDRESS_BUS = DEPTH'($urandom);
      end
      step();
      req_hist.push_back(!CS && OE);
      addr_hist.push_back(ADDRESS_BUS);
      if (i >= LATENCY-1 && req_hist[i-(LATENCY-1)]) begin
        exp_reg = model_mem[addr_hist[i-(LATENCY-1)]];
        chk("rnd_valid", DATA_VALID, 1'b1);
      end else begin
        chk("rnd_valid", DATA_VALID, 1'b0);
      end
      if (!CS && OE) chk("rnd_bus", DATA_BUS, exp_reg);
      else chk_z("rnd_bus_z", DATA_BUS);
    end

    // Reset one cycle after a request: the read is flushed.
    CS = 1'b0; OE = 1'b1; ADDRESS_BUS = 5'd5;
    step();
    RST = 1'b1; CS = 1'b1;
    #1;
    chk("midrst_valid", DATA_VALID, 1'b0);
    chk("midrst_done", LOAD_DONE, 1'b0);
    chk("midrst_checksum", CHECKSUM, 8'h00);
    step();
    chk("midrst_valid_late", DATA_VALID, 1'b0);
    RST = 1'b0;
    step();
    chk("postrst_valid", DATA_VALID, 1'b0);
    CS = 1'b0; OE = 1'b1;
    #1;
    chk("postrst_bus", DATA_BUS, 8'h00);
    LOAD_START = 1'b1;
    step();
    LOAD_START = 1'b0;
    chk("postrst_empty_start", LOAD_READY, 1'b1);
    chk("postrst_no_valid", DATA_VALID, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
